// File: rtl/pit_access_arbiter_if.sv
// Request/response/table bundle around the PIT access arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the table.
interface pit_access_arbiter_if #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6
);
  logic                int_req_valid;
  logic                int_req_ready;
  logic [PREFIX_W-1:0] int_prefix;
  logic [LEN_W-1:0]    int_len;
  logic [1:0]          int_op;
  logic                int_rsp_valid;
  logic                int_rsp_hit;
  logic [PREFIX_W-1:0] int_rsp_entry;
  logic                int_rsp_err;

  logic                dat_req_valid;
  logic                dat_req_ready;
  logic [PREFIX_W-1:0] dat_prefix;
  logic [LEN_W-1:0]    dat_len;
  logic [1:0]          dat_op;
  logic                dat_rsp_valid;
  logic                dat_rsp_hit;
  logic [PREFIX_W-1:0] dat_rsp_entry;
  logic                dat_rsp_err;

  logic                tbl_valid;
  logic [PREFIX_W-1:0] tbl_prefix;
  logic [LEN_W-1:0]    tbl_len;
  logic [1:0]          tbl_op;
  logic                tbl_done;
  logic                tbl_hit;
  logic [PREFIX_W-1:0] tbl_entry;

  logic                busy;

  modport slave (
    input  int_req_valid, int_prefix, int_len, int_op,
    input  dat_req_valid, dat_prefix, dat_len, dat_op,
    input  tbl_done, tbl_hit, tbl_entry,
    output int_req_ready, int_rsp_valid, int_rsp_hit, int_rsp_entry, int_rsp_err,
    output dat_req_ready, dat_rsp_valid, dat_rsp_hit, dat_rsp_entry, dat_rsp_err,
    output tbl_valid, tbl_prefix, tbl_len, tbl_op, busy
  );

  modport master (
    output int_req_valid, int_prefix, int_len, int_op,
    output dat_req_valid, dat_prefix, dat_len, dat_op,
    output tbl_done, tbl_hit, tbl_entry,
    input  int_req_ready, int_rsp_valid, int_rsp_hit, int_rsp_entry, int_rsp_err,
    input  dat_req_ready, dat_rsp_valid, dat_rsp_hit, dat_rsp_entry, dat_rsp_err,
    input  tbl_valid, tbl_prefix, tbl_len, tbl_op, busy
  );
endinterface

// File: rtl/pit_access_arbiter.sv
// Round-robin owner of the single PIT table port: one operation in flight,
// completion or timeout turns into a one-cycle response to the owning side.
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   ISSUE | one-cycle strobe to the table, clear timeout counter
//   WAIT  | wait for tbl_done or timeout
//   RESP  | pulse rsp_valid to owner, record last grant
module pit_access_arbiter #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int TIMEOUT  = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  pit_access_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic SIDE_INT = 1'b0;
  localparam logic SIDE_DAT = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PREFIX_W-1:0] prefix_q, prefix_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          op_q, op_d;
  logic                hit_q, hit_d;
  logic [PREFIX_W-1:0] entry_q, entry_d;
  logic                err_q, err_d;

  logic                grant_int, grant_dat;
  logic [PREFIX_W-1:0] sel_prefix;
  logic [LEN_W-1:0]    sel_len;
  logic [1:0]          sel_op;

  // On a tie the side that did not own the last operation wins.
  always_comb begin
    grant_int  = bus.int_req_valid && (!bus.dat_req_valid || last_grant_q == SIDE_DAT);
    grant_dat  = bus.dat_req_valid && (!bus.int_req_valid || last_grant_q == SIDE_INT);
    sel_prefix = grant_dat ? bus.dat_prefix : bus.int_prefix;
    sel_len    = grant_dat ? bus.dat_len    : bus.int_len;
    sel_op     = grant_dat ? bus.dat_op     : bus.int_op;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      owner_q      <= SIDE_INT;
      last_grant_q <= SIDE_DAT;
      cnt_q        <= '0;
      prefix_q     <= '0;
      len_q        <= '0;
      op_q         <= '0;
      hit_q        <= 1'b0;
      entry_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      prefix_q     <= prefix_d;
      len_q        <= len_d;
      op_q         <= op_d;
      hit_q        <= hit_d;
      entry_q      <= entry_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    prefix_d     = prefix_q;
    len_d        = len_q;
    op_d         = op_q;
    hit_d        = hit_q;
    entry_d      = entry_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_int || grant_dat) begin
          owner_d  = grant_dat;
          prefix_d = sel_prefix;
          len_d    = sel_len;
          op_d     = sel_op;
          // Zero-length prefixes and the reserved op never reach the table.
          if (sel_len == '0 || sel_op == 2'b11) begin
            err_d   = 1'b1;
            hit_d   = 1'b0;
            entry_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.tbl_done) begin
          hit_d   = bus.tbl_hit;
          entry_d = bus.tbl_entry;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          hit_d   = 1'b0;
          entry_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is gated by reset so a requester holding valid sees no accept while reset is low.
  always_comb begin
    bus.int_req_ready = rst_ni && (state_q == S_IDLE) && grant_int;
    bus.dat_req_ready = rst_ni && (state_q == S_IDLE) && grant_dat;
    bus.tbl_valid     = (state_q == S_ISSUE);
    bus.tbl_prefix    = prefix_q;
    bus.tbl_len       = len_q;
    bus.tbl_op        = op_q;
    bus.int_rsp_valid = (state_q == S_RESP) && (owner_q == SIDE_INT);
    bus.dat_rsp_valid = (state_q == S_RESP) && (owner_q == SIDE_DAT);
    bus.int_rsp_hit   = hit_q;
    bus.int_rsp_entry = entry_q;
    bus.int_rsp_err   = err_q;
    bus.dat_rsp_hit   = hit_q;
    bus.dat_rsp_entry = entry_q;
    bus.dat_rsp_err   = err_q;
    bus.busy          = (state_q != S_IDLE);
  end

endmodule
